// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: sequencing FSM that drives every enable and mux select of a
// multicycle RV32I datapath with one unified, variable-latency memory. It also
// runs the memory request/ready handshake and counts retired instructions.
module multicycle_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_i,
    input  logic [6:0]       op_i,
    input  logic [2:0]       funct3_i,
    input  logic             funct7bit_i,
    input  logic             branch_taken_i,
    input  logic             mem_ready_i,
    output logic             mem_req_o,
    output logic             mem_we_o,
    output logic             adr_src_o,
    output logic             ir_we_o,
    output logic             pc_we_o,
    output logic             pc_src_o,
    output logic             reg_we_o,
    output logic [1:0]       alu_src_a_o,
    output logic [1:0]       alu_src_b_o,
    output logic [3:0]       alu_ctrl_o,
    output logic [1:0]       result_src_o,
    output logic             retire_o,
    output logic             illegal_o,
    output logic [CNT_W-1:0] instr_cnt_o
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SLT  = 4'd3;
    localparam logic [3:0] ALU_SLTU = 4'd4;
    localparam logic [3:0] ALU_XOR  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_OR   = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWRITE, S_MEMWB,
        S_EXECR, S_EXECI, S_LUI, S_ALUWB, S_BRANCH, S_JAL,
        S_JALR1, S_JALR2, S_TRAP
    } state_t;

    state_t state, next_state;
    logic   fetch_pending;

    // funct7bit picks sub/sra for R-type but only sra for I-type (addi has no subi)
    function automatic logic [3:0] alu_decode(input logic is_r, input logic [2:0] f3,
                                              input logic f7);
        logic [3:0] code;
        case (f3)
            3'b000:  code = (is_r && f7) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            3'b101:  code = f7 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
        endcase
        return code;
    endfunction

    // State, sticky illegal flag, retire counter and outstanding-fetch flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state         <= S_FETCH;
            fetch_pending <= 1'b0;
            illegal_o     <= 1'b0;
            instr_cnt_o   <= '0;
        end else begin
            state         <= next_state;
            fetch_pending <= (state == S_FETCH) && mem_req_o && !mem_ready_i;
            if (next_state == S_TRAP) begin
                illegal_o <= 1'b1;
            end
            if (retire_o) begin
                instr_cnt_o <= instr_cnt_o + CNT_W'(1);
            end
        end
    end

    // Next state and all combinational datapath controls; everything idles in reset
    always_comb begin
        next_state   = state;
        mem_req_o    = 1'b0;
        mem_we_o     = 1'b0;
        adr_src_o    = 1'b0;
        ir_we_o      = 1'b0;
        pc_we_o      = 1'b0;
        pc_src_o     = 1'b0;
        reg_we_o     = 1'b0;
        alu_src_a_o  = 2'b00;
        alu_src_b_o  = 2'b00;
        alu_ctrl_o   = ALU_ADD;
        result_src_o = 2'b00;
        retire_o     = 1'b0;
        if (rst) begin
            case (state)
                S_FETCH: begin
                    if (run_i || fetch_pending) begin
                        mem_req_o   = 1'b1;
                        alu_src_a_o = 2'b00;
                        alu_src_b_o = 2'b10;
                        if (mem_ready_i) begin
                            ir_we_o    = 1'b1;
                            pc_we_o    = 1'b1;
                            next_state = S_DECODE;
                        end
                    end
                end
                S_DECODE: begin
                    alu_src_a_o = 2'b01;
                    alu_src_b_o = 2'b01;
                    case (op_i)
                        OP_LOAD:  next_state = S_MEMADR;
                        OP_STORE: next_state = S_MEMADR;
                        OP_R:     next_state = S_EXECR;
                        OP_I:     next_state = S_EXECI;
                        OP_BR:    next_state = S_BRANCH;
                        OP_JAL:   next_state = S_JAL;
                        OP_JALR:  next_state = S_JALR1;
                        OP_LUI:   next_state = S_LUI;
                        default:  next_state = S_TRAP;
                    endcase
                end
                S_MEMADR: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                    next_state  = (op_i == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    mem_req_o = 1'b1;
                    adr_src_o = 1'b1;
                    if (mem_ready_i) begin
                        next_state = S_MEMWB;
                    end
                end
                S_MEMWRITE: begin
                    mem_req_o = 1'b1;
                    mem_we_o  = 1'b1;
                    adr_src_o = 1'b1;
                    if (mem_ready_i) begin
                        retire_o   = 1'b1;
                        next_state = S_FETCH;
                    end
                end
                S_MEMWB: begin
                    result_src_o = 2'b01;
                    reg_we_o     = 1'b1;
                    retire_o     = 1'b1;
                    next_state   = S_FETCH;
                end
                S_EXECR: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b00;
                    alu_ctrl_o  = alu_decode(1'b1, funct3_i, funct7bit_i);
                    next_state  = S_ALUWB;
                end
                S_EXECI: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                    alu_ctrl_o  = alu_decode(1'b0, funct3_i, funct7bit_i);
                    next_state  = S_ALUWB;
                end
                S_LUI: begin
                    alu_src_a_o = 2'b11;
                    alu_src_b_o = 2'b01;
                    next_state  = S_ALUWB;
                end
                S_ALUWB: begin
                    result_src_o = 2'b00;
                    reg_we_o     = 1'b1;
                    retire_o     = 1'b1;
                    next_state   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b00;
                    alu_ctrl_o  = ALU_SUB;
                    pc_src_o    = 1'b1;
                    pc_we_o     = branch_taken_i;
                    retire_o    = 1'b1;
                    next_state  = S_FETCH;
                end
                S_JALR1: begin
                    alu_src_a_o = 2'b10;
                    alu_src_b_o = 2'b01;
                    next_state  = S_JALR2;
                end
                S_JAL, S_JALR2: begin
                    pc_src_o     = 1'b1;
                    pc_we_o      = 1'b1;
                    alu_src_a_o  = 2'b01;
                    alu_src_b_o  = 2'b10;
                    result_src_o = 2'b10;
                    reg_we_o     = 1'b1;
                    retire_o     = 1'b1;
                    next_state   = S_FETCH;
                end
                S_TRAP: begin
                    next_state = S_TRAP;
                end
                default: begin
                    next_state = S_FETCH;
                end
            endcase
        end
    end

endmodule
